// File: rtl/coremem_arbiter.sv
// Two-master (instruction fetch m0, load/store m1) arbiter onto one req/gnt/rvalid memory port.
// Define COREMEM_ARB_FIXED_PRIO_EN for fixed priority to m1; default build uses round-robin.
module coremem_arbiter #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_OUTST = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,

   input  logic                m0_req_i,
   input  logic [ADDR_W-1:0]   m0_addr_i,
   input  logic                m0_we_i,
   input  logic [DATA_W/8-1:0] m0_be_i,
   input  logic [DATA_W-1:0]   m0_wdata_i,
   output logic                m0_gnt_o,
   output logic                m0_rvalid_o,
   output logic [DATA_W-1:0]   m0_rdata_o,

   input  logic                m1_req_i,
   input  logic [ADDR_W-1:0]   m1_addr_i,
   input  logic                m1_we_i,
   input  logic [DATA_W/8-1:0] m1_be_i,
   input  logic [DATA_W-1:0]   m1_wdata_i,
   output logic                m1_gnt_o,
   output logic                m1_rvalid_o,
   output logic [DATA_W-1:0]   m1_rdata_o,

   output logic                mem_req_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic                mem_we_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   input  logic                mem_gnt_i,
   input  logic                mem_rvalid_i,
   input  logic [DATA_W-1:0]   mem_rdata_i,

   output logic                err_o
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
   localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);

   typedef enum logic {
      SEL_M0 = 1'b0,
      SEL_M1 = 1'b1
   } master_e;

   master_e          sel;
   master_e          head_id;
   master_e          id_q [MAX_OUTST];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             cnt_nz;
   logic             can_accept;
   logic             handshake;
   logic             pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

`ifdef COREMEM_ARB_FIXED_PRIO_EN
   // NOTE: every variable gets a default before any branch so no latch is inferred.
   always_comb begin
      sel = SEL_M0;
      if (m1_req_i) sel = SEL_M1;
   end
`else
   master_e rr_ptr;

   always_comb begin
      sel = SEL_M0;
      if (m0_req_i && m1_req_i) sel = rr_ptr;
      else if (m1_req_i)        sel = SEL_M1;
   end

   // Pointer moves only on a handshake, so a stalled request keeps its selection.
   always_ff @(posedge clk_i) begin
      if (!rst_ni)        rr_ptr <= SEL_M0;
      else if (handshake) rr_ptr <= master_e'(~sel);
   end
`endif

   // A response retiring this cycle frees its slot for a same-cycle grant.
   assign cnt_nz     = (cnt != '0);
   assign pop        = mem_rvalid_i & cnt_nz;
   assign can_accept = (cnt < CNT_MAX) | pop;

   assign mem_req_o   = (m0_req_i | m1_req_i) & can_accept;
   assign mem_addr_o  = (sel == SEL_M1) ? m1_addr_i  : m0_addr_i;
   assign mem_we_o    = (sel == SEL_M1) ? m1_we_i    : m0_we_i;
   assign mem_be_o    = (sel == SEL_M1) ? m1_be_i    : m0_be_i;
   assign mem_wdata_o = (sel == SEL_M1) ? m1_wdata_i : m0_wdata_i;

   assign handshake = mem_req_o & mem_gnt_i;
   assign m0_gnt_o  = handshake & (sel == SEL_M0);
   assign m1_gnt_o  = handshake & (sel == SEL_M1);

   assign head_id     = id_q[rd_ptr];
   assign m0_rvalid_o = pop & (head_id == SEL_M0);
   assign m1_rvalid_o = pop & (head_id == SEL_M1);
   assign m0_rdata_o  = mem_rdata_i;
   assign m1_rdata_o  = mem_rdata_i;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         err_o  <= 1'b0;
      end else begin
         if (handshake) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)       rd_ptr <= ptr_inc(rd_ptr);
         case ({handshake, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
         if (mem_rvalid_i && !cnt_nz) err_o <= 1'b1;
      end
   end

   // NOTE: ID storage is not reset; slots are only read after being written, guarded by cnt.
   always_ff @(posedge clk_i) begin
      if (handshake) id_q[wr_ptr] <= sel;
   end

   gnt_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(m0_gnt_o && m1_gnt_o));

   cnt_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      cnt <= CNT_MAX);

endmodule

// File: tb/tb_coremem_arbiter.sv
// Directed, table-driven bench for coremem_arbiter (default parameters, either priority mode).
module tb_coremem_arbiter;

   localparam logic [31:0] A0 = 32'h0000_1000;
   localparam logic [31:0] A1 = 32'h0000_2004;
   localparam logic [31:0] D0 = 32'h1111_1111;
   localparam logic [31:0] D1 = 32'h2222_2222;
   localparam logic [3:0]  B0 = 4'hF;
   localparam logic [3:0]  B1 = 4'h3;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        m0_req_i = 1'b0, m1_req_i = 1'b0;
   logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
   logic        m0_we_i, m1_we_i;
   logic [3:0]  m0_be_i, m1_be_i;
   logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        err_o;

   always #5 clk_i = ~clk_i;

   coremem_arbiter dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
      .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
      .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
      .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .err_o(err_o)
   );

   typedef struct {
      int   tid;
      logic rst_n, r0, r1, g, rv;
      logic mreq, g0, g1, v0, v1, err;
      int   sel;   // -1: selection not checked
   } vec_t;

   vec_t vecs[$];
   int   n_total = 0;
   int   n_pass  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic add(input int tid, input logic rst_n, r0, r1, g, rv,
                      input logic mreq, g0, g1, v0, v1, err, input int sel);
      vec_t v;
      v.tid = tid; v.rst_n = rst_n; v.r0 = r0; v.r1 = r1; v.g = g; v.rv = rv;
      v.mreq = mreq; v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.err = err; v.sel = sel;
      vecs.push_back(v);
   endtask

   task automatic add_rst(input int tid);
      add(tid, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
   endtask

   // Drive one cycle's inputs just after the falling edge, then settle before sampling.
   task automatic set_in(input logic rst_n, r0, r1, g, rv, input logic [31:0] rdata);
      @(negedge clk_i);
      rst_ni       = rst_n;
      m0_req_i     = r0;
      m1_req_i     = r1;
      mem_gnt_i    = g;
      mem_rvalid_i = rv;
      mem_rdata_i  = rdata;
      #2;
   endtask

   task automatic check_row(input int i);
      string n;
      n = $sformatf("t%0d/row%0d", vecs[i].tid, i);
      check({n, " mem_req"},   mem_req_o,   vecs[i].mreq);
      check({n, " m0_gnt"},    m0_gnt_o,    vecs[i].g0);
      check({n, " m1_gnt"},    m1_gnt_o,    vecs[i].g1);
      check({n, " m0_rvalid"}, m0_rvalid_o, vecs[i].v0);
      check({n, " m1_rvalid"}, m1_rvalid_o, vecs[i].v1);
      check({n, " err"},       err_o,       vecs[i].err);
      check({n, " m0_rdata"},  m0_rdata_o,  mem_rdata_i);
      check({n, " m1_rdata"},  m1_rdata_o,  mem_rdata_i);
      if (vecs[i].sel >= 0) begin
         check({n, " mem_addr"},  mem_addr_o,  (vecs[i].sel == 1) ? A1 : A0);
         check({n, " mem_we"},    mem_we_o,    (vecs[i].sel == 1) ? 1'b1 : 1'b0);
         check({n, " mem_be"},    mem_be_o,    (vecs[i].sel == 1) ? B1 : B0);
         check({n, " mem_wdata"}, mem_wdata_o, (vecs[i].sel == 1) ? D1 : D0);
      end
   endtask

   initial begin
      m0_addr_i = A0; m0_we_i = 1'b0; m0_be_i = B0; m0_wdata_i = D0;
      m1_addr_i = A1; m1_we_i = 1'b1; m1_be_i = B1; m1_wdata_i = D1;

      //        tid rst r0 r1 g rv   mreq g0 g1 v0 v1 err sel
      add_rst(1); add_rst(1);
      add(1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, -1);  // reset state
      add(1, 1, 1, 0, 1, 0,   1, 1, 0, 0, 0, 0,  0);  // m0 granted same cycle
      add(1, 1, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, -1);  // response to m0
      add(1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, -1);
      // FIFO full after two grants, then pop frees a slot the same cycle
      add(3, 1, 1, 0, 1, 0,   1, 1, 0, 0, 0, 0,  0);
      add(3, 1, 1, 0, 1, 0,   1, 1, 0, 0, 0, 0,  0);
      add(3, 1, 1, 0, 1, 0,   0, 0, 0, 0, 0, 0,  0);
      add(3, 1, 1, 0, 1, 1,   1, 1, 0, 1, 0, 0,  0);
      add(3, 1, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, -1);
      add(3, 1, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, -1);
      // spurious response sets sticky error; reset clears it
      add(5, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, -1);
      add(5, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, -1);
      add(5, 1, 1, 0, 1, 0,   1, 1, 0, 0, 0, 1,  0);
      add(5, 1, 0, 0, 0, 1,   0, 0, 0, 1, 0, 1, -1);
      add_rst(5);
      add(5, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, -1);
`ifdef COREMEM_ARB_FIXED_PRIO_EN
      // m1 wins every collision
      add(6, 1, 1, 1, 1, 0,   1, 0, 1, 0, 0, 0,  1);
      add(6, 1, 1, 1, 1, 1,   1, 0, 1, 0, 1, 0,  1);
      add(6, 1, 1, 1, 1, 1,   1, 0, 1, 0, 1, 0,  1);
      add(6, 1, 0, 0, 0, 1,   0, 0, 0, 0, 1, 0, -1);
`else
      // round-robin alternation with in-order routing of responses
      add(2, 1, 1, 1, 1, 0,   1, 1, 0, 0, 0, 0,  0);
      add(2, 1, 1, 1, 1, 1,   1, 0, 1, 1, 0, 0,  1);
      add(2, 1, 1, 1, 1, 1,   1, 1, 0, 0, 1, 0,  0);
      add(2, 1, 1, 1, 1, 1,   1, 0, 1, 1, 0, 0,  1);
      add(2, 1, 0, 0, 0, 1,   0, 0, 0, 0, 1, 0, -1);
      // stalled collision keeps selection; rr_ptr unchanged
      for (int k = 0; k < 4; k++)
         add(4, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      add(4, 1, 1, 1, 1, 0,   1, 1, 0, 0, 0, 0,  0);
      add(4, 1, 1, 1, 1, 0,   1, 0, 1, 0, 0, 0,  1);
      add(4, 1, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, -1);
      add(4, 1, 0, 0, 0, 1,   0, 0, 0, 0, 1, 0, -1);
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         set_in(vecs[i].rst_n, vecs[i].r0, vecs[i].r1, vecs[i].g, vecs[i].rv,
                32'hD000_0000 + 32'(i));
         if (vecs[i].rst_n) check_row(i);
      end

      // Reset with a transaction in flight: the late response is an error.
      set_in(0, 0, 0, 0, 0, '0);
      set_in(1, 1, 0, 1, 0, '0);
      check("midrst gnt", m0_gnt_o, 1'b1);
      set_in(0, 0, 0, 0, 0, '0);
      set_in(1, 0, 0, 0, 1, 32'hBEEF_0001);
      check("midrst m0_rvalid", m0_rvalid_o, 1'b0);
      check("midrst m1_rvalid", m1_rvalid_o, 1'b0);
      set_in(1, 0, 0, 0, 0, '0);
      check("midrst err", err_o, 1'b1);

      // m1 drops an ungranted request; the next grant and response belong to m0.
      set_in(0, 0, 0, 0, 0, '0);
      set_in(1, 0, 1, 0, 0, '0);
      check("drop mem_req", mem_req_o, 1'b1);
      check("drop mem_addr", mem_addr_o, A1);
      check("drop m1_gnt", m1_gnt_o, 1'b0);
      set_in(1, 0, 1, 0, 0, '0);
      set_in(1, 1, 0, 1, 0, '0);
      check("drop m0_gnt", m0_gnt_o, 1'b1);
      check("drop mem_addr m0", mem_addr_o, A0);
      set_in(1, 0, 0, 0, 1, 32'h1234_5678);
      check("drop m0_rvalid", m0_rvalid_o, 1'b1);
      check("drop m1_rvalid", m1_rvalid_o, 1'b0);
      check("drop err", err_o, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
